// File: rtl/sequence_display.sv
// Plays back a stored 2-bit-per-entry sequence on a one-hot 4-LED display, with a lit phase and a dark gap per entry.
// Optional: define SEQUENCE_DISPLAY_SPEEDUP_EN to halve the lit phase for long sequences (last index >= 16).
module sequence_display #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [32:0][1:0] segment,
    input  logic [5:0]      round,
    input  logic            start,
    output logic [3:0]      led,
    output logic            busy,
    output logic            done
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    // Timers count down from length-1 to 0, so each phase lasts exactly its length.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    state_t          state;
    logic [5:0]      index;
    logic [5:0]      last_idx;
    logic [TW-1:0]   timer;
    logic [5:0]      clamped;
    logic [5:0]      index_next;
    logic [TW-1:0]   show_load_start;
    logic [TW-1:0]   show_load_next;

    function automatic logic [3:0] decode(input logic [1:0] code);
        case (code)
            2'b11:   decode = 4'b1000;
            2'b10:   decode = 4'b0100;
            2'b01:   decode = 4'b0010;
            default: decode = 4'b0001;
        endcase
    endfunction

    assign clamped    = (round > 6'd32) ? 6'd32 : round;
    assign index_next = index + 6'd1;

`ifdef SEQUENCE_DISPLAY_SPEEDUP_EN
    localparam int HALF_ON = (ON_CYCLES / 2 > 0) ? ON_CYCLES / 2 : 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_ON - 1);

    // At start the last index is not yet registered, so decide from the clamped input.
    assign show_load_start = (clamped  >= 6'd16) ? HALF_LOAD : ON_LOAD;
    assign show_load_next  = (last_idx >= 6'd16) ? HALF_LOAD : ON_LOAD;
`else
    assign show_load_start = ON_LOAD;
    assign show_load_next  = ON_LOAD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            led      <= 4'b0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            index    <= 6'd0;
            last_idx <= 6'd0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        last_idx <= clamped;
                        index    <= 6'd0;
                        timer    <= show_load_start;
                        led      <= decode(segment[0]);
                        busy     <= 1'b1;
                        state    <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        led   <= 4'b0000;
                        timer <= OFF_LOAD;
                        state <= GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        if (index == last_idx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            index <= index_next;
                            led   <= decode(segment[index_next]);
                            timer <= show_load_next;
                            state <= SHOW;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
